sram_controller: RTL and testbench
==================================

// Module: sram_controller
// PURPOSE
//  MEM-stage data memory interface: turns one 32-bit load/store from the EXE/MEM register into
//  two 16-bit accesses on the off-chip 256Kx16 SRAM. Drives ready low while busy; ~ready is
//  the pipeline freeze, so MEM_Dest/MEM_WB_EN stay stable for the forwarding unit meanwhile.
//  Load data goes to the MEM/WB register.
// PARAMETERS
//  WAIT_CYCLES  3     cycles each 16-bit half-access is held on the SRAM pins (>=1)
//  BASE_ADDR    1024  byte address mapped to SRAM word 0
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   synchronous reset, active-high
//  MEM_R_EN    in   1   load request; held stable by the pipeline until ready=1
//  MEM_W_EN    in   1   store request; held stable by the pipeline until ready=1
//  ALU_Res     in   32  byte address
//  ST_Val      in   32  store data
//  rdata       out  32  load result {hi half, lo half}
//  ready       out  1   1 = done or idle; 0 = freeze pipeline
//  SRAM_ADDR   out  18  SRAM half-word address
//  SRAM_DQ     inout 16 SRAM data bus; driven only while writing, else high-Z
//  SRAM_WE_N   out  1   SRAM write enable, active-low
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE, cnt=0, rdata=0, SRAM_WE_N=1, SRAM_DQ=Z,
//    SRAM_ADDR=0. ready forced 1 while rst is high. A reset mid-access abandons the access,
//    with no partial rdata update.
//  - offset = ALU_Res - BASE_ADDR (32-bit wrap, no range check); ALU_Res[1:0] ignored.
//    lo half at SRAM_ADDR={offset[18:2],1'b0}; hi half at {offset[18:2],1'b1}.
//  - req = MEM_R_EN | MEM_W_EN. If both are 1, the store wins; no load occurs.
//  - ready = ~req | (state==DONE), combinational, so the freeze starts in the request cycle.
//  - FSM; cnt is a log2-sized counter 0..WAIT_CYCLES-1:
//      IDLE: req -> LO, cnt=0; else stay.
//      LO:   drive lo address; cnt++; at cnt==WAIT_CYCLES-1 -> HI, cnt=0.
//      HI:   drive hi address; cnt++; at cnt==WAIT_CYCLES-1 -> DONE.
//      DONE: ready=1 for exactly one cycle -> IDLE (unconditional).
//  - Store: SRAM_WE_N=0 for every LO/HI cycle. SRAM_DQ=ST_Val[15:0] in LO, ST_Val[31:16] in HI.
//  - Load: SRAM_WE_N=1, DQ=Z. Sample SRAM_DQ into rdata[15:0] on the last LO cycle and into
//    rdata[31:16] on the last HI cycle. rdata is valid from DONE and holds until the next load.
//  - Latency: request visible in cycle 0 gives ready=1 in cycle 2*WAIT_CYCLES+1 (7 at default).
//  - Back-to-back requests: the new request is seen in the IDLE cycle after DONE. No gap is
//    needed beyond that one cycle.
//  - Requests deasserting mid-access violate protocol; the FSM still completes the access.
//  - In IDLE/DONE: SRAM_WE_N=1, DQ=Z, SRAM_ADDR holds its last value.
// TESTING
//  1. rst=1 for 2 cycles with MEM_W_EN=1 -> ready=1, WE_N=1, DQ=Z, rdata=0, state IDLE.
//  2. Store ST_Val=0x12345678 @ALU_Res=1028 -> cycles 1-3: ADDR=2, DQ=0x5678, WE_N=0;
//     cycles 4-6: ADDR=3, DQ=0x1234, WE_N=0; cycle 7: ready=1, WE_N=1, DQ=Z.
//  3. Load @1028 with the SRAM model holding case 2's data -> ready=0 for cycles 0-6;
//     rdata=0x12345678 with ready=1 in cycle 7; DQ never driven by the DUT.
//  4. Store @1024 immediately followed by a load @1024 -> second access starts at cycle 9;
//     load returns the stored value; ready pulses exactly once per access.
//  5. rst asserted in cycle 4 of a load -> next cycle IDLE, rdata=0, WE_N=1; a new load
//     after reset completes in 7 cycles.
//  6. MEM_R_EN=MEM_W_EN=1 @1032 -> WE_N=0 at ADDR 4 then 5; rdata unchanged.
//     With no request for 20 cycles -> ready=1 throughout and WE_N=1 throughout.

Source files
------------

// File: rtl/sram_controller_if.sv
`default_nettype none
// ============================================================================
// Module  : sram_controller_if
// Brief   : MEM-stage load/store request and response bundle for the SRAM controller
// Revision: 1.0
// ============================================================================
interface sram_controller_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_Res;
  logic [31:0] ST_Val;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output MEM_R_EN, MEM_W_EN, ALU_Res, ST_Val,
    input  rdata, ready
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, ALU_Res, ST_Val,
    output rdata, ready
  );
endinterface
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module  : sram_controller
// Brief   : splits one 32-bit load/store into two 16-bit SRAM accesses, freezing the pipeline meanwhile
// Revision: 1.0
// ============================================================================
module sram_controller #(
  parameter int WAIT_CYCLES = 3,
  parameter int BASE_ADDR   = 1024
) (
  input  logic             clk,
  input  logic             rst,
  sram_controller_if.slave bus,
  output logic [17:0]      SRAM_ADDR,
  inout  wire  [15:0]      SRAM_DQ,
  output logic             SRAM_WE_N
);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wr;
  logic [15:0]      r_st_hi;
  logic [15:0]      r_lo;
  logic [15:0]      r_dq_out;
  logic             r_dq_oe;
  logic [31:0]      r_rdata;

  logic             w_req;
  logic             w_last;
  logic [16:0]      w_word;

  assign w_req  = bus.MEM_R_EN | bus.MEM_W_EN;
  assign w_last = (r_cnt == CNT_LAST);
  assign w_word = 17'((bus.ALU_Res - 32'(BASE_ADDR)) >> 2);

  assign bus.ready = rst | ~w_req | (r_state == DONE);
  assign bus.rdata = r_rdata;
  assign SRAM_DQ   = r_dq_oe ? r_dq_out : 16'bz;

  // Pin values are registered on the transition into each phase so they are
  // stable for the whole phase; SRAM_ADDR already holds the lo address when
  // entering HI, so only its LSB changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_wr      <= 1'b0;
      r_st_hi   <= '0;
      r_lo      <= '0;
      r_dq_out  <= '0;
      r_dq_oe   <= 1'b0;
      r_rdata   <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state   <= LO;
            r_cnt     <= '0;
            r_wr      <= bus.MEM_W_EN;
            r_st_hi   <= bus.ST_Val[31:16];
            r_dq_out  <= bus.ST_Val[15:0];
            r_dq_oe   <= bus.MEM_W_EN;
            SRAM_WE_N <= ~bus.MEM_W_EN;
            SRAM_ADDR <= {w_word, 1'b0};
          end
        end
        LO: begin
          if (w_last) begin
            // Lo half is parked until the hi half arrives so an abandoned load never touches rdata.
            if (!r_wr) r_lo <= SRAM_DQ;
            r_state   <= HI;
            r_cnt     <= '0;
            r_dq_out  <= r_st_hi;
            SRAM_ADDR <= {SRAM_ADDR[17:1], 1'b1};
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        HI: begin
          if (w_last) begin
            if (!r_wr) r_rdata <= {SRAM_DQ, r_lo};
            r_state   <= DONE;
            r_cnt     <= '0;
            r_dq_oe   <= 1'b0;
            SRAM_WE_N <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_sram_controller
// Brief   : scoreboard bench for sram_controller against a small behavioural SRAM
// Revision: 1.0
// ============================================================================
module tb_sram_controller;
  localparam int MAXC = 32;

  logic        clk = 1'b0;
  logic        rst;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;

  always #5 clk = ~clk;

  sram_controller_if bus();

  sram_controller #(.WAIT_CYCLES(3), .BASE_ADDR(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_WE_N (SRAM_WE_N)
  );

  // Behavioural SRAM: drives the bus whenever it is not being written.
  logic [15:0] mem [0:15];
  assign SRAM_DQ = SRAM_WE_N ? mem[SRAM_ADDR[3:0]] : 16'bz;
  always @(posedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR[3:0]] <= SRAM_DQ;

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [17:0] obs_addr [0:MAXC-1];
  logic        obs_we   [0:MAXC-1];
  logic [15:0] obs_dq   [0:MAXC-1];
  logic        obs_rdy  [0:MAXC-1];

  // Called just after a rising edge; the request is visible from cycle 0.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, output int done, output logic [31:0] rd_data);
    bus.MEM_R_EN = rd;
    bus.MEM_W_EN = wr;
    bus.ALU_Res  = addr;
    bus.ST_Val   = data;
    done    = -1;
    rd_data = 32'h0;
    for (int c = 0; c < MAXC; c++) begin
      @(negedge clk);
      obs_addr[c] = SRAM_ADDR;
      obs_we[c]   = SRAM_WE_N;
      obs_dq[c]   = SRAM_DQ;
      obs_rdy[c]  = bus.ready;
      if (bus.ready) begin
        done    = c;
        rd_data = bus.rdata;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b1;
    bus.ALU_Res  = 32'd1028;
    bus.ST_Val   = 32'hDEADBEEF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
      n_checks++; if (SRAM_WE_N !== 1'b1) begin n_fail++; $display("FAIL reset_we_n: got %b want 1", SRAM_WE_N); end
      n_checks++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
      n_checks++; if (SRAM_ADDR !== 18'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", SRAM_ADDR); end
      n_checks++; if (SRAM_DQ !== 16'h0) begin n_fail++; $display("FAIL reset_dq_undriven: got %h want 0000", SRAM_DQ); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.MEM_W_EN = 1'b0;
    @(negedge clk);
    n_checks++; if (SRAM_WE_N !== 1'b1 || bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_idle: we_n %b ready %b want 1 1", SRAM_WE_N, bus.ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    int done; logic [31:0] rd; exp_t e;
    sb.push_back('{is_load: 1'b0, data: 32'h0, lat: 7});
    run_access(1'b0, 1'b1, 32'd1028, 32'h12345678, done, rd);
    e = sb.pop_front();
    n_checks++; if (done != e.lat) begin n_fail++; $display("FAIL store_latency: got %0d want %0d", done, e.lat); end
    n_checks++; if (obs_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL store_freeze_c0: ready %b want 0", obs_rdy[0]); end
    for (int c = 1; c <= 6; c++) begin
      n_checks++;
      if (obs_addr[c] !== ((c <= 3) ? 18'd2 : 18'd3) || obs_we[c] !== 1'b0 ||
          obs_dq[c] !== ((c <= 3) ? 16'h5678 : 16'h1234) || obs_rdy[c] !== 1'b0) begin
        n_fail++;
        $display("FAIL store_cycle%0d: addr %0d we_n %b dq %h ready %b want addr %0d we_n 0 dq %h ready 0",
                 c, obs_addr[c], obs_we[c], obs_dq[c], obs_rdy[c], (c <= 3) ? 2 : 3, (c <= 3) ? 16'h5678 : 16'h1234);
      end
    end
    n_checks++; if (obs_we[7] !== 1'b1) begin n_fail++; $display("FAIL store_done_we_n: got %b want 1", obs_we[7]); end
    n_checks++; if (mem[2] !== 16'h5678 || mem[3] !== 16'h1234) begin n_fail++; $display("FAIL store_mem: got %h %h want 5678 1234", mem[2], mem[3]); end
  endtask

  task automatic test_load();
    int done; logic [31:0] rd; exp_t e;
    sb.push_back('{is_load: 1'b1, data: 32'h12345678, lat: 7});
    run_access(1'b1, 1'b0, 32'd1028, 32'hFFFFFFFF, done, rd);
    e = sb.pop_front();
    n_checks++; if (done != e.lat) begin n_fail++; $display("FAIL load_latency: got %0d want %0d", done, e.lat); end
    n_checks++; if (rd !== e.data) begin n_fail++; $display("FAIL load_rdata: got %h want %h", rd, e.data); end
    for (int c = 0; c <= 6; c++) begin
      n_checks++;
      if (obs_rdy[c] !== 1'b0 || obs_we[c] !== 1'b1 ||
          (c >= 1 && obs_dq[c] !== ((c <= 3) ? 16'h5678 : 16'h1234))) begin
        n_fail++;
        $display("FAIL load_cycle%0d: ready %b we_n %b dq %h want ready 0 we_n 1 dq %h",
                 c, obs_rdy[c], obs_we[c], obs_dq[c], (c <= 3) ? 16'h5678 : 16'h1234);
      end
    end
  endtask

  task automatic test_back_to_back();
    int done; logic [31:0] rd; exp_t e;
    sb.push_back('{is_load: 1'b0, data: 32'h0, lat: 7});
    sb.push_back('{is_load: 1'b1, data: 32'hCAFEF00D, lat: 7});
    run_access(1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, done, rd);
    e = sb.pop_front();
    n_checks++; if (done != e.lat) begin n_fail++; $display("FAIL b2b_store_latency: got %0d want %0d", done, e.lat); end
    n_checks++; if (obs_addr[1] !== 18'd0 || obs_addr[4] !== 18'd1) begin n_fail++; $display("FAIL b2b_store_addr: got %0d %0d want 0 1", obs_addr[1], obs_addr[4]); end
    run_access(1'b1, 1'b0, 32'd1024, 32'hFFFFFFFF, done, rd);
    e = sb.pop_front();
    n_checks++; if (done != e.lat) begin n_fail++; $display("FAIL b2b_load_latency: got %0d want %0d", done, e.lat); end
    n_checks++; if (rd !== e.data) begin n_fail++; $display("FAIL b2b_load_rdata: got %h want %h", rd, e.data); end
    n_checks++; if (obs_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_single_pulse: ready %b in idle cycle want 0", obs_rdy[0]); end
    n_checks++; if (obs_addr[1] !== 18'd0 || obs_we[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_load_start: addr %0d we_n %b want 0 1", obs_addr[1], obs_we[1]); end
  endtask

  task automatic test_reset_mid();
    int done; logic [31:0] rd; exp_t e;
    bus.MEM_R_EN = 1'b1;
    bus.ALU_Res  = 32'd1028;
    bus.ST_Val   = 32'hFFFFFFFF;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL midrst_no_partial: rdata %h want cafef00d", bus.rdata); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_forced: got %b want 1", bus.ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.MEM_R_EN = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.rdata !== 32'h0 || SRAM_WE_N !== 1'b1 || bus.ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_after: rdata %h we_n %b ready %b want 0 1 1", bus.rdata, SRAM_WE_N, bus.ready);
    end
    @(posedge clk); #1;
    sb.push_back('{is_load: 1'b1, data: 32'h12345678, lat: 7});
    run_access(1'b1, 1'b0, 32'd1028, 32'hFFFFFFFF, done, rd);
    e = sb.pop_front();
    n_checks++; if (done != e.lat) begin n_fail++; $display("FAIL midrst_reload_latency: got %0d want %0d", done, e.lat); end
    n_checks++; if (rd !== e.data) begin n_fail++; $display("FAIL midrst_reload_rdata: got %h want %h", rd, e.data); end
  endtask

  task automatic test_both();
    int done; logic [31:0] rd; exp_t e;
    sb.push_back('{is_load: 1'b1, data: 32'h12345678, lat: 7});
    run_access(1'b1, 1'b1, 32'd1032, 32'h0BADBEEF, done, rd);
    e = sb.pop_front();
    n_checks++; if (done != e.lat) begin n_fail++; $display("FAIL both_latency: got %0d want %0d", done, e.lat); end
    n_checks++; if (rd !== e.data) begin n_fail++; $display("FAIL both_rdata_unchanged: got %h want %h", rd, e.data); end
    for (int c = 1; c <= 6; c++) begin
      n_checks++;
      if (obs_we[c] !== 1'b0 || obs_addr[c] !== ((c <= 3) ? 18'd4 : 18'd5)) begin
        n_fail++; $display("FAIL both_cycle%0d: we_n %b addr %0d want 0 %0d", c, obs_we[c], obs_addr[c], (c <= 3) ? 4 : 5);
      end
    end
    n_checks++; if (mem[4] !== 16'hBEEF || mem[5] !== 16'h0BAD) begin n_fail++; $display("FAIL both_mem: got %h %h want beef 0bad", mem[4], mem[5]); end
  endtask

  task automatic test_idle();
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.ready !== 1'b1 || SRAM_WE_N !== 1'b1) begin
        n_fail++; $display("FAIL idle_cycle%0d: ready %b we_n %b want 1 1", i, bus.ready, SRAM_WE_N);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_reset_mid();
    test_both();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
